mem_access_ctrl: RTL and testbench

- Memory interface stage directly downstream of the SLC-3 control unit. Consumes the control unit's Mem_OE/Mem_WE requests, plus MAR/MDR from the datapath.
- Sequences the external async SRAM strobes with parameterised wait states. Decodes the memory-mapped I/O word: switches on read, hex display register on write.
- Returns read data and a one-cycle Mem_Ready. The control unit waits on Mem_Ready instead of counting fixed wait states.

---
 rtl/mem_access_ctrl_pkg.sv | 18 +
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl_sync_2ff.sv | 24 ++
 rtl/mem_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared state encoding and constants for the SLC-3 memory access stage.
package slc3_mem_pkg;

    localparam int          WAIT_CNT_W      = 4;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ACT   = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_DONE  = 3'd5,
        ST_IO_DONE  = 3'd6,
        ST_HOLD     = 3'd7
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Control-unit <-> memory-stage handshake: level requests in, read data and
// one-cycle completion pulse out.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              Mem_OE;
    logic              Mem_WE;
    logic [15:0]       MAR;
    logic [DATA_W-1:0] MDR;
    logic [DATA_W-1:0] Data_to_CPU;
    logic              Mem_Ready;
    logic              Busy;

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR,
        input  Data_to_CPU, Mem_Ready, Busy
    );

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR,
        output Data_to_CPU, Mem_Ready, Busy
    );
endinterface

// File: rtl/mem_access_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs (switch bank).
module sync_2ff #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);
    logic [DATA_W-1:0] r_meta;
    logic [DATA_W-1:0] r_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences async SRAM strobes with programmable wait states and decodes the
// memory-mapped I/O word (switches on read, hex display register on write).
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int          ADDR_W     = 20,
    parameter int          DATA_W     = 16,
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 2,
    parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_access_ctrl_if.slave   cpu,
    input  logic [DATA_W-1:0]  Switches,
    input  logic [DATA_W-1:0]  Data_from_SRAM,
    output logic [DATA_W-1:0]  Hex_Data,
    output logic [ADDR_W-1:0]  SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic [DATA_W-1:0]  Data_to_SRAM,
    output logic               SRAM_Data_OE
);
    localparam int                    WAIT_MAX = (1 << WAIT_CNT_W) - 1;
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);

    if (READ_WAIT < 0 || READ_WAIT > WAIT_MAX) begin : g_bad_read_wait
        $error("mem_access_ctrl: READ_WAIT out of range 0..15");
    end
    if (WRITE_WAIT < 1 || WRITE_WAIT > WAIT_MAX) begin : g_bad_write_wait
        $error("mem_access_ctrl: WRITE_WAIT out of range 1..15");
    end
    if (ADDR_W < 16) begin : g_bad_addr_w
        $error("mem_access_ctrl: ADDR_W must hold a 16-bit MAR");
    end

    mem_state_t            r_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [15:0]           r_mar;
    logic [DATA_W-1:0]     r_mdr;
    logic [DATA_W-1:0]     r_data_to_cpu;
    logic [DATA_W-1:0]     r_hex;

    logic [DATA_W-1:0]     w_switches_sync;
    logic                  w_request;
    logic                  w_is_io;

    sync_2ff #(.DATA_W(DATA_W)) u_sync_switches (
        .Clk   (Clk),
        .Reset (Reset),
        .i_d   (Switches),
        .o_q   (w_switches_sync)
    );

    assign w_request = cpu.Mem_OE | cpu.Mem_WE;
    assign w_is_io   = (cpu.MAR == IO_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_mar         <= '0;
            r_mdr         <= '0;
            r_data_to_cpu <= '0;
            r_hex         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_request) begin
                        r_mar <= cpu.MAR;
                        r_mdr <= cpu.MDR;
                        // Write takes priority when both requests are raised.
                        if (w_is_io) begin
                            r_state <= ST_IO_DONE;
                            if (cpu.Mem_WE) r_hex         <= cpu.MDR;
                            else            r_data_to_cpu <= w_switches_sync;
                        end else if (cpu.Mem_WE) begin
                            r_state <= ST_WR_SETUP;
                        end else begin
                            r_state <= ST_RD_ACT;
                            r_cnt   <= WAIT_CNT_W'(READ_WAIT);
                        end
                    end
                end
                ST_RD_ACT: begin
                    if (r_cnt == '0) begin
                        r_data_to_cpu <= Data_from_SRAM;
                        r_state       <= ST_RD_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_WR_SETUP: begin
                    r_cnt   <= WAIT_CNT_W'(WRITE_WAIT);
                    r_state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (r_cnt == CNT_ONE) r_state <= ST_WR_DONE;
                    else                  r_cnt   <= r_cnt - CNT_ONE;
                end
                ST_RD_DONE, ST_WR_DONE, ST_IO_DONE: begin
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Wait for the control unit to drop its request so it cannot re-issue.
                    if (!cpu.Mem_OE && !cpu.Mem_WE) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        SRAM_CE_N    = 1'b1;
        SRAM_OE_N    = 1'b1;
        SRAM_WE_N    = 1'b1;
        SRAM_UB_N    = 1'b1;
        SRAM_LB_N    = 1'b1;
        SRAM_Data_OE = 1'b0;
        case (r_state)
            ST_RD_ACT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
            end
            ST_WR_SETUP, ST_WR_DONE: begin
                SRAM_CE_N    = 1'b0;
                SRAM_UB_N    = 1'b0;
                SRAM_LB_N    = 1'b0;
                SRAM_Data_OE = 1'b1;
            end
            ST_WR_PULSE: begin
                SRAM_CE_N    = 1'b0;
                SRAM_WE_N    = 1'b0;
                SRAM_UB_N    = 1'b0;
                SRAM_LB_N    = 1'b0;
                SRAM_Data_OE = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu.Mem_Ready   = (r_state == ST_RD_DONE) || (r_state == ST_WR_DONE) ||
                             (r_state == ST_IO_DONE);
    assign cpu.Busy        = (r_state != ST_IDLE);
    assign cpu.Data_to_CPU = r_data_to_cpu;
    assign Hex_Data        = r_hex;
    assign SRAM_ADDR       = ADDR_W'(r_mar);
    assign Data_to_SRAM    = r_mdr;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: SRAM read/write timing, I/O decode,
// request hold-off, write priority and mid-access reset.
module tb_mem_access_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] Data_from_SRAM;
    logic [15:0] Hex_Data;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [15:0] Data_to_SRAM;
    logic        SRAM_Data_OE;

    int n_checks = 0;
    int n_pass   = 0;

    int ready_first, ready_cnt, oe_low_cnt, oe_low_first;
    int we_low_cnt, we_low_first, we_low_last, doe_cnt, doe_data_ok;
    int strobe_act_cnt, both_low_cnt;
    logic [15:0] hex_at_ready, cpu_at_ready;

    mem_access_ctrl_if #(.DATA_W(16)) cpu_if ();

    mem_access_ctrl #(
        .ADDR_W     (20),
        .DATA_W     (16),
        .READ_WAIT  (2),
        .WRITE_WAIT (2),
        .IO_ADDR    (16'hFFFF)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .cpu            (cpu_if),
        .Switches       (Switches),
        .Data_from_SRAM (Data_from_SRAM),
        .Hex_Data       (Hex_Data),
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_CE_N      (SRAM_CE_N),
        .SRAM_OE_N      (SRAM_OE_N),
        .SRAM_WE_N      (SRAM_WE_N),
        .SRAM_UB_N      (SRAM_UB_N),
        .SRAM_LB_N      (SRAM_LB_N),
        .Data_to_SRAM   (Data_to_SRAM),
        .SRAM_Data_OE   (SRAM_Data_OE)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic oe, input logic we, input logic [15:0] mar, input logic [15:0] mdr);
        cpu_if.Mem_OE = oe;
        cpu_if.Mem_WE = we;
        cpu_if.MAR    = mar;
        cpu_if.MDR    = mdr;
    endtask

    task automatic release_req();
        cpu_if.Mem_OE = 1'b0;
        cpu_if.Mem_WE = 1'b0;
        tick();
    endtask

    // Sample n_cyc cycles after the accepting edge; k counts edges since cycle N.
    task automatic observe(input int n_cyc, input logic [15:0] mdr);
        ready_first = 0; ready_cnt = 0; oe_low_cnt = 0; oe_low_first = 0;
        we_low_cnt = 0; we_low_first = 0; we_low_last = 0; doe_cnt = 0;
        doe_data_ok = 0; strobe_act_cnt = 0; both_low_cnt = 0;
        hex_at_ready = '0; cpu_at_ready = '0;
        for (int k = 1; k <= n_cyc; k++) begin
            tick();
            if (!SRAM_OE_N) begin
                oe_low_cnt++;
                if (oe_low_first == 0) oe_low_first = k;
            end
            if (!SRAM_WE_N) begin
                we_low_cnt++;
                if (we_low_first == 0) we_low_first = k;
                we_low_last = k;
            end
            if (SRAM_Data_OE) begin
                doe_cnt++;
                if (Data_to_SRAM == mdr) doe_data_ok++;
            end
            if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} != 5'b11111) strobe_act_cnt++;
            if (!SRAM_OE_N && !SRAM_WE_N) both_low_cnt++;
            if (cpu_if.Mem_Ready) begin
                ready_cnt++;
                if (ready_first == 0) begin
                    ready_first  = k;
                    hex_at_ready = Hex_Data;
                    cpu_at_ready = cpu_if.Data_to_CPU;
                end
            end
        end
    endtask

    initial begin
        Reset          = 1'b1;
        Switches       = '0;
        Data_from_SRAM = '0;
        issue(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) tick();

        check("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check("rst_ready",   32'(cpu_if.Mem_Ready),   32'h0);
        check("rst_busy",    32'(cpu_if.Busy),        32'h0);
        check("rst_cpu",     32'(cpu_if.Data_to_CPU), 32'h0);
        check("rst_hex",     32'(Hex_Data),           32'h0);
        check("rst_addr",    32'(SRAM_ADDR),          32'h0);
        check("rst_doe",     32'(SRAM_Data_OE),       32'h0);
        Reset = 1'b0;
        tick();

        // 1: SRAM read, READ_WAIT=2
        Data_from_SRAM = 16'hBEEF;
        issue(1'b1, 1'b0, 16'h0012, 16'h0000);
        observe(6, 16'h0000);
        check("rd_oe_cycles",  oe_low_cnt,   3);
        check("rd_oe_first",   oe_low_first, 1);
        check("rd_ready_at",   ready_first,  4);
        check("rd_ready_cnt",  ready_cnt,    1);
        check("rd_data",       32'(cpu_if.Data_to_CPU), 32'hBEEF);
        check("rd_addr",       32'(SRAM_ADDR),          32'h00012);
        check("rd_no_overlap", both_low_cnt, 0);
        release_req();

        // 2: SRAM write, WRITE_WAIT=2
        issue(1'b0, 1'b1, 16'h0040, 16'h1234);
        observe(6, 16'h1234);
        check("wr_we_cycles", we_low_cnt,   2);
        check("wr_we_first",  we_low_first, 2);
        check("wr_we_last",   we_low_last,  3);
        check("wr_doe_cnt",   doe_cnt,      4);
        check("wr_doe_data",  doe_data_ok,  4);
        check("wr_ready_at",  ready_first,  4);
        check("wr_ready_cnt", ready_cnt,    1);
        check("wr_oe_idle",   oe_low_cnt,   0);
        check("wr_addr",      32'(SRAM_ADDR), 32'h00040);
        release_req();

        // 3a: I/O write to hex register
        issue(1'b0, 1'b1, 16'hFFFF, 16'h00A5);
        observe(3, 16'h00A5);
        check("io_wr_ready_at", ready_first,        1);
        check("io_wr_hex",      32'(hex_at_ready),  32'h00A5);
        check("io_wr_strobes",  strobe_act_cnt,     0);
        check("io_wr_doe",      doe_cnt,            0);
        release_req();

        // 3b: I/O read of synchronised switches
        Switches = 16'h0F0F;
        repeat (3) tick();
        issue(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        observe(3, 16'h0000);
        check("io_rd_ready_at", ready_first,       1);
        check("io_rd_data",     32'(cpu_at_ready), 32'h0F0F);
        check("io_rd_strobes",  strobe_act_cnt,    0);
        check("io_rd_hex_kept", 32'(Hex_Data),     32'h00A5);
        release_req();

        // 4: request held long after completion
        Data_from_SRAM = 16'h5A5A;
        issue(1'b1, 1'b0, 16'h0100, 16'h0000);
        observe(14, 16'h0000);
        check("hold_ready_cnt", ready_cnt,  1);
        check("hold_oe_cycles", oe_low_cnt, 3);
        check("hold_data",      32'(cpu_if.Data_to_CPU), 32'h5A5A);
        check("hold_busy",      32'(cpu_if.Busy), 32'h1);
        cpu_if.Mem_OE = 1'b0;
        tick();
        check("hold_to_idle",   32'(cpu_if.Busy), 32'h0);

        // 5: simultaneous requests -> write
        issue(1'b1, 1'b1, 16'h0200, 16'hCAFE);
        observe(6, 16'hCAFE);
        check("both_we_cycles", we_low_cnt,  2);
        check("both_oe_idle",   oe_low_cnt,  0);
        check("both_ready_at",  ready_first, 4);
        check("both_doe_data",  doe_data_ok, 4);
        release_req();

        // 6: reset in the second RD_ACT cycle
        Data_from_SRAM = 16'h1111;
        issue(1'b1, 1'b0, 16'h0300, 16'h0000);
        tick();
        tick();
        check("abort_in_read", 32'(SRAM_OE_N), 32'h0);
        Reset         = 1'b1;
        cpu_if.Mem_OE = 1'b0;
        tick();
        check("abort_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
        check("abort_ready",   32'(cpu_if.Mem_Ready),   32'h0);
        check("abort_busy",    32'(cpu_if.Busy),        32'h0);
        check("abort_cpu",     32'(cpu_if.Data_to_CPU), 32'h0);
        Reset = 1'b0;
        observe(6, 16'h0000);
        check("abort_no_ready", ready_cnt,  0);
        check("abort_no_read",  oe_low_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
